// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: iterative reverse double-dabble BCD-to-binary converter.
// Optional saturation on overflow is enabled by defining BCD2BIN_SAT_EN.
module bcd2bin_seq #(
  parameter int NSHIFT = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [16:0] bcd,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [13:0] bin,
  output logic        err,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_IT = 4'(NSHIFT - 1);

  state_t      state_q;
  logic [30:0] z_q;
  logic [30:0] z_d;
  logic [30:0] zs;
  logic [3:0]  cnt_q;
  logic        bad_d;
  logic [13:0] bin_d;
  logic        ovf_d;

  // any decimal digit nibble above 9 makes the word invalid
  always_comb begin
    bad_d = (bcd[15:12] > 4'd9) | (bcd[11:8] > 4'd9) |
            (bcd[7:4]   > 4'd9) | (bcd[3:0]  > 4'd9);
  end

  // one shift-right step, then pull each digit >= 8 back down by 3
  always_comb begin
    zs  = z_q >> 1;
    z_d = zs;
    for (int k = 0; k < 4; k++) begin
      if (zs[14 + 4*k + 3])
        z_d[14 + 4*k +: 4] = zs[14 + 4*k +: 4] - 4'd3;
    end
  end

  // final result taken from the word produced by the last iteration;
  // any BCD residue left above bit 13 means the value exceeds 14 bits
`ifdef BCD2BIN_SAT_EN
  always_comb begin
    ovf_d = |z_d[30:14];
    bin_d = ovf_d ? 14'h3FFF : z_d[13:0];
  end
`else
  always_comb begin
    ovf_d = 1'b0;
    bin_d = z_d[13:0];
  end
`endif

  // control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      z_q     <= '0;
      cnt_q   <= '0;
      bin     <= '0;
      err     <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            ready <= 1'b0;
            if (bad_d) begin
              err     <= 1'b1;
              bin     <= '0;
              ovf     <= 1'b0;
              done    <= 1'b1;
              state_q <= S_DONE;
            end else begin
              z_q     <= {bcd, 14'b0};
              cnt_q   <= '0;
              err     <= 1'b0;
              ovf     <= 1'b0;
              busy    <= 1'b1;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          z_q   <= z_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_IT) begin
            bin     <= bin_d;
            ovf     <= ovf_d;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          ready   <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: scoreboard bench for bcd2bin_seq.
// Expected results come from decimal arithmetic on the BCD digits.
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [16:0] bcd = '0;
  logic        ready, busy, done, err, ovf;
  logic [13:0] bin;

  bcd2bin_seq dut (
    .clk(clk), .rst(rst), .start(start), .bcd(bcd),
    .ready(ready), .busy(busy), .done(done),
    .bin(bin), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [13:0] bin;
    logic        err;
    logic        ovf;
  } exp_t;

  exp_t        q[$];
  exp_t        last;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // reference: decimal value of the digits, then 14-bit binary rules
  function automatic exp_t model(input logic [16:0] b, input int at);
    exp_t e;
    int   v;
    bit   bad;
    int   d;
    bad = 0;
    v   = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'((b >> (4*i)) & 17'hF);
      if (d > 9) bad = 1;
      v = v * 10 + d;
    end
    v     = v + (b[16] ? 10000 : 0);
    e.err = bad;
    e.ovf = 1'b0;
    if (bad) begin
      e.bin = '0;
      e.cyc = at + 1;
    end else begin
`ifdef BCD2BIN_SAT_EN
      if (v > 16383) begin
        e.bin = 14'h3FFF;
        e.ovf = 1'b1;
      end else begin
        e.bin = 14'(v);
      end
`else
      e.bin = 14'(v % 16384);
`endif
      e.cyc = at + 15;
    end
    return e;
  endfunction

  // monitor: every done pulse must match the oldest pending expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done) begin
          if (q.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            e = q.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("bin", int'(bin), int'(e.bin));
            chk("err", int'(err), int'(e.err));
            chk("ovf", int'(ovf), int'(e.ovf));
            chk("busy_at_done", int'(busy), 0);
            last = e;
          end
        end else if (q.size() > 0 && cyc > q[0].cyc) begin
          fail_now("done_timeout");
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) fail_now("ready_timeout");
  endtask

  task automatic issue(input logic [16:0] b);
    wait_ready();
    chk("hold_bin", int'(bin), int'(last.bin));
    chk("hold_err", int'(err), int'(last.err));
    chk("hold_ovf", int'(ovf), int'(last.ovf));
    q.push_back(model(b, cyc));
    bcd   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcd   = 17'($urandom);
  endtask

  function automatic logic [16:0] rand_bcd();
    logic [16:0] b;
    b[16] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 4; i++)
      b[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 4) == 0)
      b[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
    return b;
  endfunction

  task automatic check_idle_reset(input string tag);
    chk({tag, "_ready"}, int'(ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_bin"}, int'(bin), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) fail_now("drain_timeout");
  endtask

  initial begin
    logic [16:0] dir [6];
    dir[0] = 17'h09999;
    dir[1] = 17'h16383;
    dir[2] = 17'h00000;
    dir[3] = 17'h19999;
    dir[4] = 17'h0A123;
    dir[5] = 17'h00042;
    last = '{cyc: 0, bin: '0, err: 1'b0, ovf: 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_reset("reset");

    foreach (dir[i]) issue(dir[i]);
    drain();

    repeat (40) issue(rand_bcd());
    drain();

    // second start during RUN must be ignored
    issue(17'h01234);
    repeat (4) @(negedge clk);
    chk("busy_in_run", int'(busy), 1);
    chk("ready_in_run", int'(ready), 0);
    bcd   = 17'h05678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    @(negedge clk);
    chk("ready_after_done", int'(ready), 1);
    repeat (5) @(negedge clk);

    // reset in the middle of a conversion
    issue(17'h13579);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_idle_reset("abort");
    last = '{cyc: 0, bin: '0, err: 1'b0, ovf: 1'b0};
    repeat (20) @(negedge clk);
    issue(17'h02468);
    drain();

    repeat (20) issue(rand_bcd());
    drain();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Iterative BCD-to-binary converter using reverse double dabble: shift right, then subtract 3 from each digit nibble ≥8.
- Inverse of the display path's binary-to-BCD converter. Accepts a 17-bit BCD word (4 full digits plus 1 ten-thousands bit) and returns a 14-bit binary value.
- Sits between keypad/switch BCD entry and the CPU datapath.
- Multi-cycle with a start/done handshake, so the combinational cost is one shift-correct stage.

Parameters:
- NSHIFT, 14: shift-correct iterations, equal to the binary output width; fixed at 14 for the 17/14-bit port widths.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- bcd  in  17  bcd[16] = ten-thousands bit; bcd[15:12], [11:8], [7:4], [3:0] = thousands..units
- ready  out  1  high in IDLE only
- busy  out  1  high in RUN only
- done  out  1  one-cycle pulse when the result is valid
- bin  out  14  binary result; held from done until the next accepted start
- err  out  1  invalid digit in the captured word; valid with done, held like bin
- ovf  out  1  value >16383; valid with done (see Optional Feature)

Behaviour:
- Reset (rst high at a clk edge):
  - State = IDLE; bin = 0, err = 0, ovf = 0, done = 0, busy = 0, ready = 1; iteration counter = 0.
  - Reset aborts any conversion in progress; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE with start = 1, all four nibbles ≤9:
  - Load work register z[30:0] = {bcd, 14'b0}.
  - Counter = 0; err = 0, ovf = 0; go to RUN.
- IDLE with start = 1, any nibble >9:
  - err = 1, bin = 0, ovf = 0; go to DONE. Conversion is skipped.
- RUN, each cycle:
  - zs = z >> 1.
  - For each nibble zs[29:26], [25:22], [21:18], [17:14]: if ≥8, subtract 3.
  - Write z = corrected zs; counter++.
  - After the 14th iteration (counter = 13 at the edge), go to DONE.
- Result when entering DONE from RUN:
  - bin = z[13:0].
  - Overflow = (z[30:14] != 0), i.e. residual BCD content remains.
- DONE: done = 1 for exactly one cycle; unconditional return to IDLE on the next edge.
- Latency:
  - Valid conversion: done visible 15 cycles after the edge that sampled start (14 RUN + 1).
  - Invalid digit: done visible 1 cycle after the start edge.
- start outside IDLE (RUN or DONE) is ignored; no queueing.
- bcd is sampled only at the accepting edge; later changes have no effect.
- bin, err and ovf change only on entry to DONE or on reset.
- Arithmetic:
  - Each nibble correction is 4-bit unsigned and cannot underflow, since it is applied only when the nibble is ≥8.
  - bcd[16] needs no correction; it participates only by shifting.

Optional Feature:
- Macro BCD2BIN_SAT_EN defined:
  - Overflow check active: on overflow, ovf = 1 and bin = 14'h3FFF (saturated).
- Macro not defined:
  - No overflow logic; ovf is tied to 0.
  - bin = true value mod 16384 (z[13:0]).
- err behaviour is identical in both builds.

Test Plan:
- Reset, then start with bcd = 17'h09999 → done at cycle 15; bin = 14'h270F, err = 0, ovf = 0.
- bcd = 17'h16383 → bin = 14'h3FFF, ovf = 0. bcd = 17'h00000 → bin = 0.
- bcd = 17'h19999:
  - With BCD2BIN_SAT_EN → bin = 14'h3FFF, ovf = 1.
  - Without it → bin = 14'h0E1F, ovf = 0.
- bcd = 17'h0A123 → done 1 cycle after start; err = 1, bin = 0. Then bcd = 17'h00042 → err clears, bin = 14'h002A.
- start pulsed again at RUN cycle 5 with a different bcd → ignored; exactly one done with the first result; ready returns 1 after DONE.
- rst asserted at RUN cycle 7 → next cycle IDLE, all outputs 0, ready = 1, no done pulse; a new start converts correctly.
